// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, word size and J-format field widths.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam int          WORD_SHIFT = 2;
    localparam int          JIDX_W     = 26;
    localparam int          JHI_W      = 4;
    localparam int          WAIT_W     = 8;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational redirect target selection for branch, jump and jump-register.
// A jump takes priority over a branch raised in the same cycle.
module fetch_target_calc
    import fetch_pkg::*;
(
    input  logic              branch,
    input  logic [31:0]       offset,
    input  logic              jump,
    input  logic              jump_sel,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic [31:0]       jump_reg,
    input  logic [31:0]       base_pc,
    output logic [31:0]       target,
    output logic              redirect
);

    logic signed [31:0] offset_s;
    logic signed [31:0] byte_offset_s;

    assign offset_s      = signed'(offset);
    assign byte_offset_s = offset_s <<< WORD_SHIFT;

    always_comb begin
        redirect = branch | jump;
        target   = base_pc + unsigned'(byte_offset_s);
        if (jump) begin
            if (jump_sel) begin
                target = jump_reg;
            end else begin
                target = {base_pc[31:32-JHI_W], jump_index, 2'b00};
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch path controller: owns the PC, runs the imem req/ack handshake and
// presents each fetched word to decode, handling redirects mid-fetch.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              ImemReq,
    output logic [31:0]       ImemAddr,
    input  logic              ImemAck,
    input  logic [31:0]       ImemData,
    output logic [31:0]       Instruction,
    output logic              InstrValid,
    input  logic              DecodeReady,
    output logic [31:0]       NextInstruct,
    input  logic              Branch,
    input  logic [31:0]       InstructOffset,
    input  logic              Jump,
    input  logic              JumpSel,
    input  logic [JIDX_W-1:0] JumpInstruction,
    input  logic [31:0]       JumpRegister,
    input  logic [31:0]       BasePC,
    output logic              ImemTimeout
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    fetch_state_t      state;
    logic [31:0]       pc;
    logic [31:0]       pending;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic [31:0]       target;
    logic              redirect;

    fetch_target_calc u_target (
        .branch     (Branch),
        .offset     (InstructOffset),
        .jump       (Jump),
        .jump_sel   (JumpSel),
        .jump_index (JumpInstruction),
        .jump_reg   (JumpRegister),
        .base_pc    (BasePC),
        .target     (target),
        .redirect   (redirect)
    );

    assign ImemAddr = pc;
    assign wait_inc = sat_inc(wait_cnt);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            pending      <= '0;
            wait_cnt     <= '0;
            ImemReq      <= 1'b0;
            InstrValid   <= 1'b0;
            Instruction  <= '0;
            NextInstruct <= '0;
            ImemTimeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_REQ;
                    ImemReq  <= 1'b1;
                    wait_cnt <= '0;
                end
                ST_REQ: begin
                    if (ImemAck) begin
                        wait_cnt <= '0;
                        if (redirect) begin
                            // Word is stale; the new request goes out next cycle.
                            pc <= target;
                        end else begin
                            Instruction  <= ImemData;
                            NextInstruct <= pc + WORD_BYTES;
                            pc           <= pc + WORD_BYTES;
                            InstrValid   <= 1'b1;
                            ImemReq      <= 1'b0;
                            state        <= ST_VALID;
                        end
                    end else if (redirect) begin
                        // Request cannot be withdrawn; finish it at the old address.
                        pending  <= target;
                        wait_cnt <= '0;
                        state    <= ST_DRAIN;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc >= MAX_WAIT_C) ImemTimeout <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (redirect) begin
                        InstrValid <= 1'b0;
                        pc         <= target;
                        ImemReq    <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= ST_REQ;
                    end else if (DecodeReady) begin
                        InstrValid <= 1'b0;
                        ImemReq    <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (ImemAck) begin
                        pc       <= redirect ? target : pending;
                        wait_cnt <= '0;
                        state    <= ST_REQ;
                    end else begin
                        if (redirect) pending <= target;
                        wait_cnt <= wait_inc;
                        if (wait_inc >= MAX_WAIT_C) ImemTimeout <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ImemReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by randomized traffic
// checked against a transaction-level reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 15;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        DecodeReady;
    logic [31:0] NextInstruct;
    logic        Branch;
    logic [31:0] InstructOffset;
    logic        Jump;
    logic        JumpSel;
    logic [25:0] JumpInstruction;
    logic [31:0] JumpRegister;
    logic [31:0] BasePC;
    logic        ImemTimeout;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .ImemReq         (ImemReq),
        .ImemAddr        (ImemAddr),
        .ImemAck         (ImemAck),
        .ImemData        (ImemData),
        .Instruction     (Instruction),
        .InstrValid      (InstrValid),
        .DecodeReady     (DecodeReady),
        .NextInstruct    (NextInstruct),
        .Branch          (Branch),
        .InstructOffset  (InstructOffset),
        .Jump            (Jump),
        .JumpSel         (JumpSel),
        .JumpInstruction (JumpInstruction),
        .JumpRegister    (JumpRegister),
        .BasePC          (BasePC),
        .ImemTimeout     (ImemTimeout)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic respond(input logic en);
        ImemAck  = en & ImemReq;
        ImemData = memf(ImemAddr);
    endtask

    task automatic clear_redirect();
        Branch          = 1'b0;
        Jump            = 1'b0;
        JumpSel         = 1'b0;
        JumpInstruction = '0;
        JumpRegister    = '0;
        InstructOffset  = '0;
        BasePC          = '0;
    endtask

    // Reference model state for the randomized phase
    logic [31:0] exp_addr, req_addr, m_instr, m_next, tgt;
    logic        m_valid, doomed, req_active, redir;
    int          waitc;

    initial begin
        Reset       = 1'b1;
        ImemAck     = 1'b0;
        ImemData    = '0;
        DecodeReady = 1'b0;
        clear_redirect();

        repeat (2) @(negedge Clk);
        check("rst_req",   ImemReq,      0);
        check("rst_vld",   InstrValid,   0);
        check("rst_instr", Instruction,  0);
        check("rst_next",  NextInstruct, 0);
        check("rst_tmo",   ImemTimeout,  0);
        check("rst_addr",  ImemAddr,     RESET_PC);
        Reset       = 1'b0;
        DecodeReady = 1'b1;

        // Back-to-back fetches, 1-cycle ack, decode always ready
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (i % 2 == 0) begin
                check("t1_req",  ImemReq,    1);
                check("t1_addr", ImemAddr,   32'(4 * (i / 2)));
                check("t1_vld0", InstrValid, 0);
            end else begin
                check("t1_vld",   InstrValid,   1);
                check("t1_next",  NextInstruct, 32'(4 * (i / 2) + 4));
                check("t1_instr", Instruction,  memf(32'(4 * (i / 2))));
                check("t1_req0",  ImemReq,      0);
            end
            respond(1'b1);
        end

        // Decode stall holds the word
        @(negedge Clk);
        check("t2_addr", ImemAddr, 32'h10);
        respond(1'b1);
        DecodeReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("t2_vld",   InstrValid,   1);
            check("t2_instr", Instruction,  memf(32'h10));
            check("t2_next",  NextInstruct, 32'h14);
            check("t2_req0",  ImemReq,      0);
            respond(1'b1);
        end
        DecodeReady = 1'b1;
        @(negedge Clk);
        check("t2_req",   ImemReq,  1);
        check("t2_addr2", ImemAddr, 32'h14);
        respond(1'b1);

        // Branch in VALID squashes the word
        @(negedge Clk);
        check("t3_vld", InstrValid, 1);
        Branch         = 1'b1;
        BasePC         = 32'h40;
        InstructOffset = 32'hFFFF_FFFC;
        respond(1'b1);
        @(negedge Clk);
        check("t3_addr", ImemAddr,   32'h30);
        check("t3_vld0", InstrValid, 0);
        clear_redirect();
        respond(1'b1);

        // Jump and branch together: jump-register wins
        @(negedge Clk);
        check("t4_instr", Instruction, memf(32'h30));
        Branch       = 1'b1;
        Jump         = 1'b1;
        JumpSel      = 1'b1;
        JumpRegister = 32'h200;
        BasePC       = 32'h40;
        respond(1'b1);
        @(negedge Clk);
        check("t4_addr", ImemAddr, 32'h200);
        clear_redirect();
        respond(1'b1);
        @(negedge Clk);
        Jump         = 1'b1;
        JumpSel      = 1'b1;
        JumpRegister = 32'h8;
        respond(1'b1);

        // Redirect while a request is outstanding
        @(negedge Clk);
        check("t5_addr8", ImemAddr, 32'h8);
        JumpRegister = 32'h100;
        ImemAck      = 1'b0;
        @(negedge Clk);
        clear_redirect();
        for (int i = 0; i < 2; i++) begin
            check("t5_hold", ImemAddr,   32'h8);
            check("t5_req",  ImemReq,    1);
            check("t5_vld0", InstrValid, 0);
            if (i == 0) @(negedge Clk);
        end
        ImemAck  = 1'b1;
        ImemData = 32'hBAD0_0008;
        @(negedge Clk);
        check("t5_addr100", ImemAddr,   32'h100);
        check("t5_drop",    InstrValid, 0);
        ImemAck      = 1'b0;
        Jump         = 1'b1;
        JumpSel      = 1'b1;
        JumpRegister = 32'h300;
        @(negedge Clk);
        check("t5_hold2", ImemAddr, 32'h100);
        clear_redirect();
        Branch         = 1'b1;
        BasePC         = 32'h80;
        InstructOffset = 32'h4;
        @(negedge Clk);
        check("t5_hold3", ImemAddr, 32'h100);
        clear_redirect();
        ImemAck = 1'b1;
        @(negedge Clk);
        check("t5_latest", ImemAddr,   32'h90);
        check("t5_drop2",  InstrValid, 0);
        ImemAck = 1'b0;

        // Ack withheld until timeout, then async reset mid-request
        for (int i = 1; i <= MAX_WAIT + 1; i++) begin
            @(negedge Clk);
            if (i == MAX_WAIT - 1) check("t6_tmo0", ImemTimeout, 0);
            if (i == MAX_WAIT)     check("t6_tmo1", ImemTimeout, 1);
            if (i == MAX_WAIT + 1) check("t6_hold", ImemAddr,    32'h90);
        end
        respond(1'b1);
        @(negedge Clk);
        check("t6_vld",    InstrValid,  1);
        check("t6_instr",  Instruction, memf(32'h90));
        check("t6_sticky", ImemTimeout, 1);
        respond(1'b1);
        @(negedge Clk);
        check("t6_addr94", ImemAddr, 32'h94);
        ImemAck = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check("t6_rreq",  ImemReq,     0);
        check("t6_rpc",   ImemAddr,    RESET_PC);
        check("t6_rtmo",  ImemTimeout, 0);
        check("t6_rvld",  InstrValid,  0);
        @(negedge Clk);
        Reset = 1'b0;

        // Randomized traffic against the reference model
        exp_addr   = RESET_PC;
        req_addr   = '0;
        m_instr    = '0;
        m_next     = '0;
        m_valid    = 1'b0;
        doomed     = 1'b0;
        req_active = 1'b0;
        waitc      = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge Clk);
            check("r_req", ImemReq,     !m_valid);
            check("r_vld", InstrValid,  m_valid);
            check("r_tmo", ImemTimeout, 0);
            if (ImemReq) begin
                if (!req_active) begin
                    check("r_addr", ImemAddr, exp_addr);
                    req_addr   = ImemAddr;
                    req_active = 1'b1;
                end else begin
                    check("r_hold", ImemAddr, req_addr);
                end
            end
            if (m_valid) begin
                check("r_instr", Instruction,  m_instr);
                check("r_next",  NextInstruct, m_next);
            end

            ImemAck         = ImemReq && (waitc >= 8 || $urandom_range(0, 2) == 0);
            ImemData        = $urandom;
            DecodeReady     = 1'($urandom_range(0, 1));
            begin
                int r;
                r = $urandom_range(0, 9);
                Branch = (r == 0) || (r == 2);
                Jump   = (r == 1) || (r == 2);
            end
            JumpSel         = 1'($urandom_range(0, 1));
            JumpInstruction = 26'($urandom);
            JumpRegister    = $urandom & 32'hFFFF_FFFC;
            BasePC          = $urandom & 32'hFFFF_FFFC;
            InstructOffset  = 32'($urandom_range(0, 63)) - 32'd32;

            redir = Branch | Jump;
            if (Jump) tgt = JumpSel ? JumpRegister : {BasePC[31:28], JumpInstruction, 2'b00};
            else      tgt = BasePC + InstructOffset * 32'd4;

            if (ImemReq) begin
                if (ImemAck) begin
                    waitc      = 0;
                    req_active = 1'b0;
                    if (redir) begin
                        exp_addr = tgt;
                    end else if (!doomed) begin
                        m_valid  = 1'b1;
                        m_instr  = ImemData;
                        m_next   = req_addr + 32'd4;
                        exp_addr = req_addr + 32'd4;
                    end
                    doomed = 1'b0;
                end else begin
                    waitc++;
                    if (redir) begin
                        doomed   = 1'b1;
                        exp_addr = tgt;
                    end
                end
            end else if (m_valid) begin
                if (redir) begin
                    m_valid  = 1'b0;
                    exp_addr = tgt;
                end else if (DecodeReady) begin
                    m_valid = 1'b0;
                end
            end
        end
        @(negedge Clk);
        ImemAck = 1'b0;
        clear_redirect();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
